// File: rtl/rv32v_types_pkg.sv
// Shared types for the fetch2 -> vector decode path.
//   word_t       : 32-bit instruction / address word
//   fdq_entry_t  : one fetch-decode queue slot (instr, pc, malformed, fault)
//   FDQ_DEFAULT_* : default geometry of rv32v_fetch_decode_queue
package rv32v_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  mal;
    logic  fault;
  } fdq_entry_t;

  localparam int unsigned FDQ_DEFAULT_DEPTH       = 8;
  localparam int unsigned FDQ_DEFAULT_FETCH_WIDTH = 2;
  localparam int unsigned FDQ_MAX_FETCH_WIDTH     = 4;

endpackage

// File: rtl/rv32v_fdq_lane_count.sv
// Lane acceptance logic for the fetch-decode queue (purely combinational).
// Accepts the leading run of valid lanes starting at lane 0, and stops after
// the first accepted lane that carries a malformed or fault flag.
// Ports:
//   accept      : queue is taking a group this cycle
//   lane_valid  : per-lane valid, lane 0 oldest
//   lane_mal    : per-lane malformed flag
//   lane_fault  : per-lane fetch-fault flag
//   npush       : number of lanes accepted (0..FETCH_WIDTH)
//   lane_we     : per-lane accept (always a contiguous run from lane 0)
//   fault_hit   : an accepted lane carried mal/fault
module rv32v_fdq_lane_count
  import rv32v_types_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = FDQ_DEFAULT_FETCH_WIDTH
) (
  input  logic                   accept,
  input  logic [FETCH_WIDTH-1:0] lane_valid,
  input  logic [FETCH_WIDTH-1:0] lane_mal,
  input  logic [FETCH_WIDTH-1:0] lane_fault,
  output logic [2:0]             npush,
  output logic [FETCH_WIDTH-1:0] lane_we,
  output logic                   fault_hit
);

  logic lane_open;

  always_comb begin
    npush     = '0;
    lane_we   = '0;
    fault_hit = 1'b0;
    lane_open = accept;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (lane_open && lane_valid[i]) begin
        lane_we[i] = 1'b1;
        npush      = npush + 3'd1;
        // A flagged lane is kept, but nothing younger in its group is.
        if (lane_mal[i] || lane_fault[i]) begin
          fault_hit = 1'b1;
          lane_open = 1'b0;
        end
      end else begin
        lane_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rv32v_fetch_decode_queue.sv
// Instruction queue between fetch stage 2 and vector decode.
// Takes up to FETCH_WIDTH instructions per cycle, presents one per cycle to
// decode over a valid/ready handshake, supports flush and a fault stall that
// blocks further pushes until flush.
// Optional build macro: RV32V_FDQ_BYPASS_EN -- when the queue is empty, a
// pushed lane 0 is shown to decode in the same cycle (and skipped from
// storage if decode takes it).
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   flush        : drop all entries, clear fault stall (highest priority)
//   push_*       : FETCH_WIDTH-lane push group, lane 0 oldest
//   push_ready   : a full group can be taken this cycle
//   dec_*        : head entry to decode, zero when dec_valid=0
//   dec_ready    : decode takes the head when dec_valid
//   count        : current occupancy
module rv32v_fetch_decode_queue
  import rv32v_types_pkg::*;
#(
  parameter int unsigned DEPTH       = FDQ_DEFAULT_DEPTH,
  parameter int unsigned FETCH_WIDTH = FDQ_DEFAULT_FETCH_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic [FETCH_WIDTH-1:0]    push_valid,
  input  logic [32*FETCH_WIDTH-1:0] push_instr,
  input  logic [32*FETCH_WIDTH-1:0] push_pc,
  input  logic [FETCH_WIDTH-1:0]    push_mal,
  input  logic [FETCH_WIDTH-1:0]    push_fault,
  output logic                      push_ready,
  output logic                      dec_valid,
  output logic [31:0]               dec_instr,
  output logic [31:0]               dec_pc,
  output logic                      dec_mal,
  output logic                      dec_fault,
  input  logic                      dec_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // push_ready <=> DEPTH - count >= FETCH_WIDTH
  localparam cnt_t READY_MAX = cnt_t'(DEPTH - FETCH_WIDTH);

  if ((DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth_pow2
    $error("rv32v_fetch_decode_queue: DEPTH must be a power of 2");
  end
  if (DEPTH < FETCH_WIDTH) begin : g_chk_depth_ge_width
    $error("rv32v_fetch_decode_queue: DEPTH must be >= FETCH_WIDTH");
  end
  if ((FETCH_WIDTH < 1) || (FETCH_WIDTH > FDQ_MAX_FETCH_WIDTH)) begin : g_chk_width
    $error("rv32v_fetch_decode_queue: FETCH_WIDTH must be 1..4");
  end

  fdq_entry_t mem_q [DEPTH];
  fdq_entry_t mem_d [DEPTH];
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  cnt_t       count_q, count_d;
  logic       fault_stall_q, fault_stall_d;

  fdq_entry_t             lane_entry [FETCH_WIDTH];
  fdq_entry_t             head;
  fdq_entry_t             out_entry;
  logic                   out_valid;
  logic                   accept;
  logic [2:0]             npush;
  logic [2:0]             store_n;
  logic [FETCH_WIDTH-1:0] lane_we;
  logic                   fault_hit;
  logic                   mem_valid;
  logic                   pop_mem;
  logic                   bypass_take;

  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      lane_entry[i] = '{instr: push_instr[32*i +: 32],
                        pc:    push_pc[32*i +: 32],
                        mal:   push_mal[i],
                        fault: push_fault[i]};
    end
  end

  assign push_ready = (count_q <= READY_MAX) && !fault_stall_q;
  assign accept     = push_ready && !flush && !RST;
  assign mem_valid  = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  rv32v_fdq_lane_count #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_lane_count (
    .accept     (accept),
    .lane_valid (push_valid),
    .lane_mal   (push_mal),
    .lane_fault (push_fault),
    .npush      (npush),
    .lane_we    (lane_we),
    .fault_hit  (fault_hit)
  );

`ifdef RV32V_FDQ_BYPASS_EN
  logic bypass_act;
  assign bypass_act  = !mem_valid && lane_we[0];
  assign bypass_take = bypass_act && dec_ready;
  assign out_valid   = mem_valid || bypass_act;
  assign out_entry   = bypass_act ? lane_entry[0] : head;
`else
  assign bypass_take = 1'b0;
  assign out_valid   = mem_valid;
  assign out_entry   = head;
`endif

  assign pop_mem = mem_valid && dec_ready && !flush;
  assign store_n = npush - {2'b00, bypass_take};

  always_comb begin
    mem_d = mem_q;
    // A bypassed lane 0 takes no slot, so younger lanes slide down by one.
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (lane_we[i] && !(bypass_take && (i == 0))) begin
        mem_d[wr_ptr_q + ptr_t'(i) - ptr_t'(bypass_take)] = lane_entry[i];
      end
    end
  end

  always_comb begin
    count_d       = count_q + cnt_t'(store_n) - cnt_t'(pop_mem);
    wr_ptr_d      = wr_ptr_q + ptr_t'(store_n);
    rd_ptr_d      = rd_ptr_q + ptr_t'(pop_mem);
    fault_stall_d = fault_stall_q | fault_hit;
    if (flush) begin
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      fault_stall_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fault_stall_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fault_stall_q <= fault_stall_d;
    end
  end

  // Storage is never cleared; dec_valid qualifies everything read from it.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign dec_valid = out_valid;
  assign dec_instr = out_valid ? out_entry.instr : '0;
  assign dec_pc    = out_valid ? out_entry.pc    : '0;
  assign dec_mal   = out_valid && out_entry.mal;
  assign dec_fault = out_valid && out_entry.fault;
  assign count     = count_q;

endmodule

// File: tb/tb_rv32v_fetch_decode_queue.sv
module tb_rv32v_fetch_decode_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned FW    = 2;
  localparam logic [31:0] IMASK = 32'hC0DE_0000;

  logic              CLK = 1'b0;
  logic              RST;
  logic              flush;
  logic [FW-1:0]     push_valid;
  logic [32*FW-1:0]  push_instr;
  logic [32*FW-1:0]  push_pc;
  logic [FW-1:0]     push_mal;
  logic [FW-1:0]     push_fault;
  logic              push_ready;
  logic              dec_valid;
  logic [31:0]       dec_instr;
  logic [31:0]       dec_pc;
  logic              dec_mal;
  logic              dec_fault;
  logic              dec_ready;
  logic [3:0]        count;

  int total = 0;
  int bad   = 0;

  rv32v_fetch_decode_queue #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (FW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .push_valid (push_valid),
    .push_instr (push_instr),
    .push_pc    (push_pc),
    .push_mal   (push_mal),
    .push_fault (push_fault),
    .push_ready (push_ready),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_mal    (dec_mal),
    .dec_fault  (dec_fault),
    .dec_ready  (dec_ready),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    push_valid = '0;
    push_instr = '0;
    push_pc    = '0;
    push_mal   = '0;
    push_fault = '0;
    flush      = 1'b0;
    dec_ready  = 1'b0;
  endtask

  task automatic set_lane(input int unsigned lane, input logic [31:0] pc,
                          input logic mal, input logic fault);
    push_valid[lane]          = 1'b1;
    push_pc[32*lane +: 32]    = pc;
    push_instr[32*lane +: 32] = pc ^ IMASK;
    push_mal[lane]            = mal;
    push_fault[lane]          = fault;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
    total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
    total++; if (dec_instr !== 32'h0) begin bad++; $display("FAIL reset_dec_instr: got %h want 0", dec_instr); end
    total++; if (dec_fault !== 1'b0 || dec_mal !== 1'b0) begin bad++; $display("FAIL reset_dec_flags: got %b%b want 00", dec_mal, dec_fault); end
  endtask

  task automatic test_fill();
    idle();
    for (int g = 0; g < 4; g++) begin
      push_valid = '0;
      set_lane(0, 32'(8*g), 1'b0, 1'b0);
      set_lane(1, 32'(8*g+4), 1'b0, 1'b0);
      tick();
      if (g == 2) begin
        total++; if (count !== 4'd6) begin bad++; $display("FAIL fill_count6: got %0d want 6", count); end
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL fill_ready6: got %b want 1", push_ready); end
      end
      if (g == 3) begin
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count8: got %0d want 8", count); end
        total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL fill_ready8: got %b want 0", push_ready); end
      end
    end
    // push into a full queue is ignored
    push_valid = '0;
    set_lane(0, 32'hDEAD_0000, 1'b0, 1'b0);
    set_lane(1, 32'hDEAD_0004, 1'b0, 1'b0);
    tick();
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_full_ignore: got %0d want 8", count); end
    total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL fill_head_hold: got %h want 0", dec_pc); end
    idle();
    dec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4*k)) begin bad++; $display("FAIL fill_drain_pc%0d: got v=%b pc=%h want v=1 pc=%h", k, dec_valid, dec_pc, 32'(4*k)); end
      total++; if (dec_instr !== (32'(4*k) ^ IMASK)) begin bad++; $display("FAIL fill_drain_instr%0d: got %h want %h", k, dec_instr, 32'(4*k) ^ IMASK); end
      tick();
    end
    total++; if (count !== 4'd0 || dec_valid !== 1'b0) begin bad++; $display("FAIL fill_empty: got count=%0d v=%b want 0 0", count, dec_valid); end
    idle();
  endtask

  task automatic test_wrap();
    do_flush();
    for (int n = 0; n < 5; n++) begin
      push_valid = '0;
      set_lane(0, 32'h1000 + 32'(4*n), 1'b0, 1'b0);
      tick();
    end
    idle();
    dec_ready = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    idle();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_setup_empty: got %0d want 0", count); end
    // read and write pointers now sit at 5
    for (int g = 0; g < 3; g++) begin
      push_valid = '0;
      set_lane(0, 32'h2000 + 32'(8*g), 1'b0, 1'b0);
      set_lane(1, 32'h2004 + 32'(8*g), 1'b0, 1'b0);
      tick();
    end
    push_valid = '0;
    total++; if (count !== 4'd6 || push_ready !== 1'b1) begin bad++; $display("FAIL wrap_setup6: got count=%0d rdy=%b want 6 1", count, push_ready); end
    for (int c = 0; c < 20; c++) begin
      push_valid = '0;
      set_lane(0, 32'h2000 + 32'(4*(6+c)), 1'b0, 1'b0);
      dec_ready = 1'b1;
      #1;
      total++; if (dec_pc !== 32'h2000 + 32'(4*c)) begin bad++; $display("FAIL wrap_pc%0d: got %h want %h", c, dec_pc, 32'h2000 + 32'(4*c)); end
      tick();
      total++; if (count !== 4'd6) begin bad++; $display("FAIL wrap_count%0d: got %0d want 6", c, count); end
    end
    idle();
    dec_ready = 1'b1;
    for (int c = 20; c < 26; c++) begin
      #1;
      total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h2000 + 32'(4*c)) begin bad++; $display("FAIL wrap_tail%0d: got v=%b pc=%h want v=1 pc=%h", c, dec_valid, dec_pc, 32'h2000 + 32'(4*c)); end
      tick();
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_end_empty: got %0d want 0", count); end
    idle();
  endtask

  task automatic test_noncontig();
    do_flush();
    push_valid = '0;
    set_lane(1, 32'h300, 1'b0, 1'b0);
    tick();
    push_valid = '0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL noncontig_count: got %0d want 0", count); end
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL noncontig_valid: got %b want 0", dec_valid); end
    set_lane(0, 32'h304, 1'b0, 1'b0);
    tick();
    push_valid = '0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL lane0_count: got %0d want 1", count); end
    total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h304) begin bad++; $display("FAIL lane0_head: got v=%b pc=%h want v=1 pc=304", dec_valid, dec_pc); end
    do_flush();
  endtask

  task automatic test_fault();
    do_flush();
    set_lane(0, 32'h40, 1'b0, 1'b1);
    set_lane(1, 32'h44, 1'b0, 1'b0);
    #1;
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL fault_pre_ready: got %b want 1", push_ready); end
    tick();
    push_valid = '0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL fault_count: got %0d want 1", count); end
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL fault_stall: got %b want 0", push_ready); end
    total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h40) begin bad++; $display("FAIL fault_head: got v=%b pc=%h want v=1 pc=40", dec_valid, dec_pc); end
    total++; if (dec_fault !== 1'b1 || dec_mal !== 1'b0) begin bad++; $display("FAIL fault_flags: got mal=%b fault=%b want 0 1", dec_mal, dec_fault); end
    set_lane(0, 32'h48, 1'b0, 1'b0);
    tick();
    push_valid = '0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL fault_push_blocked: got %0d want 1", count); end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    total++; if (count !== 4'd0 || dec_valid !== 1'b0) begin bad++; $display("FAIL fault_drained: got count=%0d v=%b want 0 0", count, dec_valid); end
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL fault_stall_hold: got %b want 0", push_ready); end
    do_flush();
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL fault_flush_clear: got %b want 1", push_ready); end
    // malformed on lane 1 keeps both lanes and stalls
    set_lane(0, 32'h50, 1'b0, 1'b0);
    set_lane(1, 32'h54, 1'b1, 1'b0);
    tick();
    push_valid = '0;
    total++; if (count !== 4'd2 || push_ready !== 1'b0) begin bad++; $display("FAIL mal_count: got count=%0d rdy=%b want 2 0", count, push_ready); end
    dec_ready = 1'b1;
    #1;
    total++; if (dec_pc !== 32'h50 || dec_mal !== 1'b0) begin bad++; $display("FAIL mal_head0: got pc=%h mal=%b want 50 0", dec_pc, dec_mal); end
    tick();
    total++; if (dec_pc !== 32'h54 || dec_mal !== 1'b1) begin bad++; $display("FAIL mal_head1: got pc=%h mal=%b want 54 1", dec_pc, dec_mal); end
    tick();
    do_flush();
  endtask

  task automatic test_flush();
    do_flush();
    set_lane(0, 32'h80, 1'b0, 1'b0); set_lane(1, 32'h84, 1'b0, 1'b0); tick();
    set_lane(0, 32'h88, 1'b0, 1'b0); set_lane(1, 32'h8C, 1'b0, 1'b0); tick();
    push_valid = '0;
    set_lane(0, 32'h90, 1'b0, 1'b0); tick();
    push_valid = '0;
    total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_setup5: got %0d want 5", count); end
    flush = 1'b1;
    dec_ready = 1'b1;
    set_lane(0, 32'hA0, 1'b0, 1'b0);
    set_lane(1, 32'hA4, 1'b0, 1'b0);
    tick();
    idle();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
    total++; if (dec_valid !== 1'b0 || dec_pc !== 32'h0) begin bad++; $display("FAIL flush_dec: got v=%b pc=%h want 0 0", dec_valid, dec_pc); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", push_ready); end
    set_lane(0, 32'h100, 1'b0, 1'b0);
    tick();
    push_valid = '0;
    total++; if (count !== 4'd1 || dec_valid !== 1'b1 || dec_pc !== 32'h100) begin bad++; $display("FAIL flush_repush: got count=%0d v=%b pc=%h want 1 1 100", count, dec_valid, dec_pc); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++; if (count !== 4'd0 || dec_valid !== 1'b0 || push_ready !== 1'b1) begin bad++; $display("FAIL midrst: got count=%0d v=%b rdy=%b want 0 0 1", count, dec_valid, push_ready); end
  endtask

  task automatic test_bypass();
    idle();
    set_lane(0, 32'h200, 1'b0, 1'b0);
    set_lane(1, 32'h204, 1'b0, 1'b0);
    dec_ready = 1'b1;
    #1;
`ifdef RV32V_FDQ_BYPASS_EN
    total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200) begin bad++; $display("FAIL bypass_same_cycle: got v=%b pc=%h want 1 200", dec_valid, dec_pc); end
`else
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL nobypass_same_cycle: got v=%b want 0", dec_valid); end
`endif
    tick();
    idle();
`ifdef RV32V_FDQ_BYPASS_EN
    total++; if (count !== 4'd1 || dec_pc !== 32'h204) begin bad++; $display("FAIL bypass_next: got count=%0d pc=%h want 1 204", count, dec_pc); end
`else
    total++; if (count !== 4'd2 || dec_pc !== 32'h200) begin bad++; $display("FAIL nobypass_next: got count=%0d pc=%h want 2 200", count, dec_pc); end
`endif
    do_flush();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_wrap();
    test_noncontig();
    test_fault();
    test_flush();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
